// File: rtl/urisc_prog_loader_pkg.sv
// Shared definitions for the URISC program loader and program memory.
// Holds the program-memory geometry defaults, the frame header value,
// the loader state encoding and the wrap-around checksum helper, so the
// loader, the RAM and the core all agree on one set of numbers.
package urisc_prog_loader_pkg;

  localparam int         ADDR_W_DEF    = 7;
  localparam int         DEPTH_DEF     = 1 << ADDR_W_DEF;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         WORD_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } ld_state_t;

  // Checksum accumulation is plain mod-256 addition.
  function automatic logic [7:0] sum_wrap8(input logic [7:0] a,
                                           input logic [7:0] b);
    return a + b;
  endfunction

  // States in which a frame is being received.
  function automatic logic ld_in_frame(input ld_state_t s);
    return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_HI) ||
           (s == ST_LO)   || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/urisc_prog_ram.sv
// URISC program store: simple dual-port RAM, synchronous write and
// synchronous (registered) read. The loader owns the write port; the core
// fetches through the read port with the same address/data widths.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data, valid the cycle after rd_addr is presented
module urisc_prog_ram
  import urisc_prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/urisc_prog_loader.sv
// Byte-stream loader for the URISC program memory.
// Accepts a frame  SYNC, LEN, LEN x {hi, lo}, CSUM  over a valid/ready
// handshake, writes the assembled 16-bit words to addresses 0..LEN-1 and
// releases the core from reset only when the mod-256 sum of LEN, all data
// bytes and CSUM is zero.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          pulse: begin/restart a load (ignored while busy)
//   byte_in        stream byte, byte_valid qualifies it, byte_ready accepts it
//   wr_en/addr/data  program memory write port
//   cpu_reset_n    core reset, high only after a clean load
//   busy           frame reception in progress
//   done, error    outcome of the last load (levels)
//   words_loaded   words written in the current or last frame
module urisc_prog_loader
  import urisc_prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         DEPTH     = DEPTH_DEF,   // must equal 2**ADDR_W
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ld_state_t  state, state_nx;
  logic [7:0] len_p0;
  logic [7:0] sum_p0;
  logic [7:0] hi_p0;
  logic       accept;
  logic       len_bad;
  logic       last_word;
  logic       csum_ok;

  assign accept    = byte_valid && byte_ready;
  assign len_bad   = (byte_in == 8'd0) || (32'(byte_in) > 32'(DEPTH));
  // words_loaded counts accepted LO bytes, so the one being taken now is
  // word number words_loaded+1.
  assign last_word = ((words_loaded + 8'd1) == len_p0);
  assign csum_ok   = (sum_wrap8(sum_p0, byte_in) == 8'h00);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nx = ST_SYNC;
      end
      ST_SYNC: begin
        if (accept && (byte_in == SYNC_BYTE)) state_nx = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_nx = len_bad ? ST_ERR : ST_HI;
      end
      ST_HI: begin
        if (accept) state_nx = ST_LO;
      end
      ST_LO: begin
        if (accept) state_nx = last_word ? ST_CSUM : ST_HI;
      end
      ST_CSUM: begin
        if (accept) state_nx = csum_ok ? ST_DONE : ST_ERR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register so an
  // asynchronous reset forces them to their idle values immediately.
  always_comb begin
    busy        = ld_in_frame(state);
    byte_ready  = ld_in_frame(state);
    done        = (state == ST_DONE);
    error       = (state == ST_ERR);
    cpu_reset_n = (state == ST_DONE);
  end

  // Stage p0: byte capture and checksum; stage p1: memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_p0       <= 8'd0;
      sum_p0       <= 8'd0;
      hi_p0        <= 8'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 16'd0;
      words_loaded <= 8'd0;
    end else begin
      state <= state_nx;
      wr_en <= 1'b0;
      // Address steps past each written word; after word DEPTH it wraps to 0,
      // which is harmless because the frame is over by then.
      if (wr_en) begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            sum_p0       <= 8'd0;
            wr_addr      <= '0;
            words_loaded <= 8'd0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len_p0 <= byte_in;
            sum_p0 <= byte_in;
          end
        end
        ST_HI: begin
          if (accept) begin
            hi_p0  <= byte_in;
            sum_p0 <= sum_wrap8(sum_p0, byte_in);
          end
        end
        ST_LO: begin
          if (accept) begin
            sum_p0       <= sum_wrap8(sum_p0, byte_in);
            wr_en        <= 1'b1;
            wr_data      <= {hi_p0, byte_in};
            words_loaded <= words_loaded + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
